// File: rtl/data_mem_if_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_if_if
// Description : Bus bundle between the datapath and the data-memory
//               interface block.
//               master  - datapath side: issues load/store requests and
//                         receives load data, stall and alignment error.
//               slave   - memory side: accepts requests, returns data_in,
//                         stall and align_err.
//               Signals : mem_read, mem_write (requests), data_adr (byte
//                         address), data_out (store data), data_in (load
//                         data), stall (freeze request), align_err (pulse).
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_if_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] data_adr;
   logic [31:0] data_out;
   logic [31:0] data_in;
   logic        stall;
   logic        align_err;

   modport master (
      output mem_read, mem_write, data_adr, data_out,
      input  data_in, stall, align_err
   );

   modport slave (
      input  mem_read, mem_write, data_adr, data_out,
      output data_in, stall, align_err
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_if
// Description : Multi-cycle data memory with a datapath-facing stall
//               handshake. A request seen in IDLE is latched, waits
//               WAIT_CYCLES cycles in BUSY, commits on the edge into DONE
//               and returns to IDLE one cycle later.
//               Ports   : clk       - rising-edge clock
//                         rst       - synchronous active-high reset
//                         bus       - data_mem_if_if.slave bundle
//                                     (mem_read, mem_write, data_adr,
//                                      data_out, data_in, stall, align_err)
//               Params  : WAIT_CYCLES - BUSY cycles per access (0..15)
//                         ADR_W       - word-index width (2^ADR_W words)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_if #(
   parameter int WAIT_CYCLES = 2,
   parameter int ADR_W       = 8
) (
   input wire            clk,
   input wire            rst,
   data_mem_if_if.slave  bus
);

   localparam int         c_DEPTH     = 1 << ADR_W;
   localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic              r_wr;
   logic [ADR_W+1:0]  r_adr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_data_in;
   logic              r_align_err;
   logic [31:0]       r_mem [c_DEPTH];

   logic              w_req;
   logic              w_stall;
   logic              w_commit;
   logic              w_src_wr;
   logic [ADR_W+1:0]  w_src_adr;
   logic [31:0]       w_src_data;
   logic [ADR_W-1:0]  w_idx;
   logic              w_mis;
   logic              w_unused_adr;

   // Upper address bits are deliberately discarded: addresses wrap.
   assign w_unused_adr = ^bus.data_adr[31:ADR_W+2];

   assign w_req = bus.mem_read | bus.mem_write;

   // With WAIT_CYCLES=0 the commit happens on the same edge that would
   // otherwise latch the request, so the commit source is the live inputs.
   assign w_src_wr   = (r_state == ST_IDLE) ? bus.mem_write                : r_wr;
   assign w_src_adr  = (r_state == ST_IDLE) ? bus.data_adr[ADR_W+1:0]      : r_adr;
   assign w_src_data = (r_state == ST_IDLE) ? bus.data_out                 : r_wdata;
   assign w_idx      = w_src_adr[ADR_W+1:2];
   assign w_mis      = |w_src_adr[1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               w_stall = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  w_state_nxt = ST_DONE;
                  w_commit    = 1'b1;
               end else begin
                  w_state_nxt = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            w_stall = 1'b1;
            if (r_cnt == 4'd0) begin
               w_state_nxt = ST_DONE;
               w_commit    = 1'b1;
            end
         end
         // Requests seen here belong to the instruction now completing.
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
      // Reset wins over everything, including the combinational stall.
      if (rst) begin
         w_state_nxt = ST_IDLE;
         w_stall     = 1'b0;
         w_commit    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_wr        <= 1'b0;
         r_adr       <= '0;
         r_wdata     <= 32'h0;
         r_data_in   <= 32'h0;
         r_align_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_align_err <= w_commit & w_mis;
         if ((r_state == ST_IDLE) && w_req) begin
            r_wr    <= bus.mem_write;
            r_adr   <= bus.data_adr[ADR_W+1:0];
            r_wdata <= bus.data_out;
            r_cnt   <= c_WAIT_LOAD;
         end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_commit && !w_src_wr) begin
            r_data_in <= w_mis ? 32'h0 : r_mem[w_idx];
         end
      end
   end

   // Storage is not reset; w_commit is already gated by rst.
   always_ff @(posedge clk) begin
      if (w_commit && w_src_wr && !w_mis) begin
         r_mem[w_idx] <= w_src_data;
      end
   end

   assign bus.data_in   = r_data_in;
   assign bus.stall     = w_stall;
   assign bus.align_err = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_if
// Description : Self-checking bench for data_mem_if. A transaction-level
//               model (word array plus expected per-cycle outputs of an
//               access timeline) is compared with the DUT every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_if;

   localparam int WAIT = 2;
   localparam int AW   = 8;
   localparam int WORDS = 1 << AW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_mem_if_if bus ();

   data_mem_if #(.WAIT_CYCLES(WAIT), .ADR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_chk = 0;
   int          n_fail = 0;
   int          stall_seen = 0;
   int          align_seen = 0;
   bit          chk_en = 1'b0;
   logic        exp_stall;
   logic        exp_align;
   logic [31:0] exp_data;
   logic [31:0] m_data_in;
   logic [31:0] m_mem [WORDS];

   // Single per-cycle compare against the model's expectations.
   always @(negedge clk) begin
      if (chk_en) begin
         n_chk++;
         if (bus.stall !== exp_stall) begin
            n_fail++;
            $display("FAIL stall t=%0t actual=%b required=%b", $time, bus.stall, exp_stall);
         end
         n_chk++;
         if (bus.align_err !== exp_align) begin
            n_fail++;
            $display("FAIL align_err t=%0t actual=%b required=%b", $time, bus.align_err, exp_align);
         end
         n_chk++;
         if (bus.data_in !== exp_data) begin
            n_fail++;
            $display("FAIL data_in t=%0t actual=%h required=%h", $time, bus.data_in, exp_data);
         end
         if (bus.stall === 1'b1) stall_seen++;
         if (bus.align_err === 1'b1) align_seen++;
      end
   end

   task automatic lit_check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.mem_read  = 1'b0;
         bus.mem_write = 1'b0;
         bus.data_adr  = $urandom;
         bus.data_out  = $urandom;
         exp_stall = 1'b0;
         exp_align = 1'b0;
         exp_data  = m_data_in;
         @(posedge clk); #1;
      end
   endtask

   // One access as seen by the datapath: request held until DONE, junk on
   // the request lines during DONE. rst_at asserts reset in that cycle.
   task automatic access(input bit rd, input bit wr, input logic [31:0] adr,
                         input logic [31:0] wdata, input int rst_at);
      int unsigned a;
      int          idx;
      bit          mis;
      int          s0;
      int          a0;
      a   = adr;
      idx = int'((a % (4 * WORDS)) / 4);
      mis = (a % 4) != 0;
      s0  = stall_seen;
      a0  = align_seen;
      for (int k = 0; k <= WAIT + 1; k++) begin
         if (k == WAIT + 1) begin
            bus.mem_read  = 1'($urandom);
            bus.mem_write = 1'($urandom);
            bus.data_adr  = $urandom;
            bus.data_out  = $urandom;
            if (wr) begin
               if (!mis) m_mem[idx] = wdata;
            end else begin
               m_data_in = mis ? 32'h0 : m_mem[idx];
            end
            exp_stall = 1'b0;
            exp_align = mis;
            exp_data  = m_data_in;
         end else begin
            bus.mem_read  = rd;
            bus.mem_write = wr;
            bus.data_adr  = adr;
            bus.data_out  = wdata;
            exp_stall = 1'b1;
            exp_align = 1'b0;
            exp_data  = m_data_in;
            if (k == rst_at) begin
               rst = 1'b1;
               exp_stall = 1'b0;
               #1;
               lit_check("stall_in_reset_cycle", 32'(bus.stall), 32'h0);
            end
         end
         @(posedge clk); #1;
         if (k == rst_at) begin
            rst = 1'b0;
            m_data_in = 32'h0;
            return;
         end
      end
      lit_check("stall_length", 32'(stall_seen - s0), 32'(WAIT + 1));
      lit_check("align_pulses", 32'(align_seen - a0), 32'(mis ? 1 : 0));
   endtask

   initial begin
      logic [31:0] ra;
      rst = 1'b1;
      bus.mem_read  = 1'b1;
      bus.mem_write = 1'b0;
      bus.data_adr  = 32'h0;
      bus.data_out  = 32'h0;
      exp_stall = 1'b0;
      exp_align = 1'b0;
      exp_data  = 32'h0;
      m_data_in = 32'h0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);
      lit_check("reset_data_in", bus.data_in, 32'h0);
      lit_check("reset_stall", 32'(bus.stall), 32'h0);
      lit_check("reset_align", 32'(bus.align_err), 32'h0);

      // Fill every word so later reads have known contents.
      for (int i = 0; i < WORDS; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, -1);

      // Directed: store then load.
      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, -1);
      access(1'b1, 1'b0, 32'h10, 32'h0, -1);
      lit_check("store_load", bus.data_in, 32'hDEADBEEF);
      lit_check("model_store_load", m_data_in, 32'hDEADBEEF);
      idle(1);

      // Misaligned read, then confirm memory unchanged.
      access(1'b1, 1'b0, 32'h13, 32'h0, -1);
      lit_check("misaligned_read", bus.data_in, 32'h0);
      access(1'b1, 1'b0, 32'h10, 32'h0, -1);
      lit_check("after_mis_read", bus.data_in, 32'hDEADBEEF);

      // Misaligned write is suppressed.
      access(1'b0, 1'b1, 32'h12, 32'h1, -1);
      access(1'b1, 1'b0, 32'h10, 32'h0, -1);
      lit_check("mis_write_suppressed", bus.data_in, 32'hDEADBEEF);

      // Read and write together: write wins, data_in untouched.
      access(1'b1, 1'b1, 32'h10, 32'h00000077, -1);
      lit_check("rw_keeps_data_in", bus.data_in, 32'hDEADBEEF);
      access(1'b1, 1'b0, 32'h10, 32'h0, -1);
      lit_check("rw_is_write", bus.data_in, 32'h00000077);

      // Address wrap.
      access(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, -1);
      access(1'b1, 1'b0, 32'h000, 32'h0, -1);
      lit_check("wrap", bus.data_in, 32'hA5A5A5A5);

      // Reset in the second BUSY cycle of a write cancels it.
      access(1'b0, 1'b1, 32'h20, 32'h0BADF00D, -1);
      access(1'b0, 1'b1, 32'h20, 32'h00000055, 2);
      idle(1);
      lit_check("reset_clears_data_in", bus.data_in, 32'h0);
      access(1'b1, 1'b0, 32'h20, 32'h0, -1);
      lit_check("reset_cancels_write", bus.data_in, 32'h0BADF00D);

      // Back-to-back reads.
      access(1'b0, 1'b1, 32'h4, 32'hCAFEF00D, -1);
      access(1'b1, 1'b0, 32'h0, 32'h0, -1);
      lit_check("b2b_first", bus.data_in, 32'hA5A5A5A5);
      access(1'b1, 1'b0, 32'h4, 32'h0, -1);
      lit_check("b2b_second", bus.data_in, 32'hCAFEF00D);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         bit rd;
         bit wr;
         ra = $urandom;
         if ($urandom_range(3) != 0) ra[1:0] = 2'b00;
         rd = 1'($urandom);
         wr = 1'($urandom);
         if (!rd && !wr) rd = 1'b1;
         if ($urandom_range(19) == 0) begin
            access(rd, wr, ra, $urandom, int'($urandom_range(WAIT)));
            idle(1);
         end else begin
            access(rd, wr, ra, $urandom, -1);
            idle(int'($urandom_range(2)));
         end
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_mem_if.md
DATA_MEM_IF -- requirements
Module: data_mem_if

Interface
REQ-001 The block SHALL provide parameter WAIT_CYCLES, default 2, giving the number of BUSY cycles per access (legal 0..15).
REQ-002 The block SHALL provide parameter ADR_W, default 8, giving the word-index width, so depth is 2^ADR_W 32-bit words.
REQ-003 The block SHALL provide these ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  load request from the datapath.
- mem_write  input  1  store request from the datapath.
- data_adr  input  32  byte address; this is the datapath ALU result.
- data_out  input  32  store data; this is the datapath read_data2.
- data_in  output  32  load data, registered, fed to the datapath mem_to_reg mux.
- stall  output  1  freeze request to PC and register-file write enable.
- align_err  output  1  one-cycle pulse flagging a misaligned access.

Function
REQ-004 The block SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-005 In IDLE, a request (mem_read or mem_write high) SHALL latch op, data_adr and data_out at the clock edge.
- If WAIT_CYCLES>0 the FSM SHALL move to BUSY and load the 4-bit wait counter with WAIT_CYCLES-1.
- If WAIT_CYCLES=0 the FSM SHALL move directly to DONE.
REQ-006 In BUSY, the counter SHALL decrement each cycle; when it is 0 the FSM SHALL move to DONE at that edge.
REQ-007 The access SHALL commit at the edge entering DONE:
- a write stores the latched data at word index latched_adr[ADR_W+1:2];
- a read loads data_in from that index.
REQ-008 DONE SHALL last exactly one cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-009 Request inputs present during DONE SHALL be ignored, because they belong to the instruction completing in that cycle.
REQ-010 stall SHALL be combinational:
- high in IDLE while a request is present;
- high throughout BUSY;
- low in DONE;
- low in IDLE with no request.
REQ-011 An access with a request first seen in IDLE SHALL therefore hold stall high for exactly WAIT_CYCLES+1 cycles; the datapath advances on the edge that ends DONE.
REQ-012 When mem_read and mem_write are both high, the access SHALL be a write, and data_in SHALL keep its prior value.
REQ-013 data_in SHALL hold its value until the next read commits; writes SHALL NOT change it.
REQ-014 If latched_adr[1:0] != 0:
- the write SHALL be suppressed;
- a read SHALL load 32'h0 into data_in;
- align_err SHALL be high for the DONE cycle only.
REQ-015 Address bits above ADR_W+1 SHALL be ignored, so addresses wrap modulo 2^(ADR_W+2) bytes.
REQ-016 Non-request cycles in IDLE SHALL leave memory, data_in and the FSM unchanged.

Reset
REQ-017 rst high at an edge SHALL force:
- FSM to IDLE;
- wait counter to 0;
- data_in to 32'h0;
- align_err to 0;
- stall to 0 for the reset cycle, overriding REQ-010.
REQ-018 Reset during BUSY SHALL cancel the access: a pending write never commits, and data_in becomes 0.
REQ-019 Reset SHALL NOT clear memory contents.
REQ-020 rst asserted simultaneously with a request SHALL win; the request is not latched.

Verification
REQ-021 All scenarios use WAIT_CYCLES=2. The bench SHALL cover at least these directed scenarios:
- Store then load: write 32'hDEADBEEF to 0x10, then read 0x10 -> stall high 3 cycles for each access; data_in=32'hDEADBEEF in the read's DONE cycle.
- Misaligned read of 0x13 -> align_err pulses in DONE; data_in=0; memory unchanged.
- Misaligned write of 32'h1 to 0x12, then read 0x10 -> data_in shows the old word, not 1.
- Wrap: write 32'hA5A5A5A5 to 0x400, then read 0x000 -> data_in=32'hA5A5A5A5 (ADR_W=8).
- Reset in the second BUSY cycle of a write of 32'h55 to 0x20, then read 0x20 -> data_in shows the previous contents; stall=0 in the reset cycle.
- Back-to-back: reads of 0x0 and 0x4 on consecutive instructions -> second stall starts the cycle after DONE; no request is lost or duplicated.
